// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one external comparator among NREQ requesters.
// One transaction at a time: IDLE -> EVAL (grant) -> RESP (held until accepted).
module cmp_sched #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [N-1:0]      cmp_a,
  output logic [N-1:0]      cmp_b,
  input  logic              cmp_less,
  input  logic              cmp_equal,
  input  logic              cmp_greater,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_less,
  output logic              rsp_equal,
  output logic              rsp_greater,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Response handshake: a response transfers on a rising edge where
  // rsp_valid and rsp_ready are both high; while rsp_valid is high and
  // rsp_ready is low, rsp_id and all rsp_* results stay unchanged.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] win;
  logic           found;
  int             rr_idx;
  logic [2:0]     exp_res;
  logic           res_bad;

  // Scan ptr, ptr+1, ... wrapping; the first pending request wins.
  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[rr_idx]) begin
        found = 1'b1;
        win   = IDW'(rr_idx);
      end
    end
  end

  // Expected result is one-hot, so a single mismatch test also catches
  // non-one-hot comparator outputs.
  always_comb begin
    exp_res = {cmp_a < cmp_b, cmp_a == cmp_b, cmp_a > cmp_b};
    res_bad = ({cmp_less, cmp_equal, cmp_greater} != exp_res);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = EVAL;
      EVAL:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      gnt         <= '0;
      cmp_a       <= '0;
      cmp_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_less    <= 1'b0;
      rsp_equal   <= 1'b0;
      rsp_greater <= 1'b0;
      err         <= 1'b0;
    end else begin
      gnt <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            cmp_a    <= req_a[int'(win)*N +: N];
            cmp_b    <= req_b[int'(win)*N +: N];
            rsp_id   <= win;
            gnt[win] <= 1'b1;
          end
        end
        EVAL: begin
          rsp_less    <= cmp_less;
          rsp_equal   <= cmp_equal;
          rsp_greater <= cmp_greater;
          rsp_valid   <= 1'b1;
          if (res_bad) err <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr_q     <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule
